// File: rtl/rx_pkg.sv
// Shared definitions for the receive-side OFDM baseband demodulator.
// Contents:
//   rx_state_t  - sequencing FSM state encoding (3 bits)
//   N_SUB_DEF   - default subcarriers (FFT bins) per OFDM symbol
//   TIMEOUT_DEF - default watchdog limit in cycles
//   CP_LEN_DEF  - default cyclic-prefix length, used by the CPR/FFT blocks
package rx_pkg;

    localparam int N_SUB_DEF   = 64;
    localparam int TIMEOUT_DEF = 1023;
    localparam int CP_LEN_DEF  = 16;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CPR   = 3'd1,
        FFT   = 3'd2,
        DEMAP = 3'd3,
        P2S   = 3'd4
    } rx_state_t;

endpackage

// File: rtl/rx_controller_if.sv
// Control bundle between the receive controller and its environment.
// Signals:
//   go, abort                      - requests from the host
//   CPR/FFT/DEMAP/P2S_done         - completion pulses from the sub-blocks
//   CPR/FFT/DEMAP/P2S_start        - one-cycle start pulses to the sub-blocks
//   bin_idx, busy, sym_done, err   - status towards the host
//   state                          - current FSM state, for observation only
// Modports: master = controller side, slave = host/sub-block side.
//
// Handshake: a sub-block is kicked by a one-cycle start pulse and answers
// with a one-cycle done pulse. A done is honoured in any cycle of the
// matching wait state, including the cycle in which the start is high;
// a done seen in any other state is dropped without effect.
interface rx_controller_if #(
    parameter int N_SUB = rx_pkg::N_SUB_DEF
);
    import rx_pkg::*;

    localparam int BIN_W = $clog2(N_SUB);

    logic             go;
    logic             abort;
    logic             CPR_done;
    logic             FFT_done;
    logic             DEMAP_done;
    logic             P2S_done;
    logic             CPR_start;
    logic             FFT_start;
    logic             DEMAP_start;
    logic             P2S_start;
    logic [BIN_W-1:0] bin_idx;
    logic             busy;
    logic             sym_done;
    logic             err;
    rx_state_t        state;

    modport master (
        input  go, abort, CPR_done, FFT_done, DEMAP_done, P2S_done,
        output CPR_start, FFT_start, DEMAP_start, P2S_start,
        output bin_idx, busy, sym_done, err, state
    );

    modport slave (
        output go, abort, CPR_done, FFT_done, DEMAP_done, P2S_done,
        input  CPR_start, FFT_start, DEMAP_start, P2S_start,
        input  bin_idx, busy, sym_done, err, state
    );

endinterface

// File: rtl/rx_watchdog.sv
// Generic wait-state watchdog, shared with the transmit controller.
// Ports:
//   clk, rst - clock, asynchronous active-low reset
//   clr      - force the count to zero (has priority over en)
//   en       - count this cycle (waiting and nothing has arrived)
//   expire   - high in the cycle where an enabled count sits at TIMEOUT-1
module rx_watchdog #(
    parameter int TIMEOUT = 1023,
    parameter int WD_W    = $clog2(TIMEOUT + 1)
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expire
);

    localparam logic [WD_W-1:0] LAST = WD_W'(TIMEOUT - 1);

    logic [WD_W-1:0] wd_cnt;

    assign expire = en && (wd_cnt == LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wd_cnt <= '0;
        end else if (clr) begin
            wd_cnt <= '0;
        end else if (en) begin
            wd_cnt <= expire ? '0 : wd_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/rx_controller.sv
// Receive-side OFDM sequencing FSM. Per symbol: CPR, FFT, then for each bin
// DEMAP followed by P2S. Every output is registered, so start pulses appear
// one cycle after the event that causes them.
// Ports:
//   clk  - clock
//   rst  - asynchronous active-low reset
//   bus  - rx_controller_if.master (go/abort, start/done pairs, status, state)
module rx_controller
    import rx_pkg::*;
#(
    parameter int N_SUB   = N_SUB_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF,
    parameter int BIN_W   = $clog2(N_SUB),
    parameter int WD_W    = $clog2(TIMEOUT + 1)
) (
    input logic            clk,
    input logic            rst,
    rx_controller_if.master bus
);

    localparam logic [BIN_W-1:0] LAST_BIN = BIN_W'(N_SUB - 1);

    rx_state_t        state, state_nxt;
    logic             match;
    logic             expire;
    logic             wd_clr, wd_en;

    logic             cpr_q, fft_q, demap_q, p2s_q, sym_q, err_q, busy_q;
    logic             cpr_d, fft_d, demap_d, p2s_d, sym_d, err_d, busy_d;
    logic [BIN_W-1:0] bin_q, bin_d;

    // The done pulse belonging to the current wait state; all others are ignored.
    always_comb begin
        match = 1'b0;
        case (state)
            CPR:     match = bus.CPR_done;
            FFT:     match = bus.FFT_done;
            DEMAP:   match = bus.DEMAP_done;
            P2S:     match = bus.P2S_done;
            default: match = 1'b0;
        endcase
    end

    // Watchdog counts only while waiting without an answer; any state change
    // (including abort and the IDLE dwell) restarts it from zero.
    assign wd_en  = (state != IDLE) && !match;
    assign wd_clr = bus.abort || (state == IDLE) || (state_nxt != state);

    rx_watchdog #(
        .TIMEOUT (TIMEOUT),
        .WD_W    (WD_W)
    ) u_watchdog (
        .clk    (clk),
        .rst    (rst),
        .clr    (wd_clr),
        .en     (wd_en),
        .expire (expire)
    );

    // State and output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            cpr_q   <= 1'b0;
            fft_q   <= 1'b0;
            demap_q <= 1'b0;
            p2s_q   <= 1'b0;
            sym_q   <= 1'b0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
            bin_q   <= '0;
        end else begin
            state   <= state_nxt;
            cpr_q   <= cpr_d;
            fft_q   <= fft_d;
            demap_q <= demap_d;
            p2s_q   <= p2s_d;
            sym_q   <= sym_d;
            err_q   <= err_d;
            busy_q  <= busy_d;
            bin_q   <= bin_d;
        end
    end

    // Next state. A matching done beats watchdog expiry in the same cycle,
    // and abort beats everything.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (bus.go) state_nxt = CPR;
            CPR:   if (match) state_nxt = FFT;
                   else if (expire) state_nxt = IDLE;
            FFT:   if (match) state_nxt = DEMAP;
                   else if (expire) state_nxt = IDLE;
            DEMAP: if (match) state_nxt = P2S;
                   else if (expire) state_nxt = IDLE;
            P2S:   if (match) state_nxt = (bin_q == LAST_BIN) ? IDLE : DEMAP;
                   else if (expire) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (bus.abort) state_nxt = IDLE;
    end

    // Next values of the registered outputs.
    always_comb begin
        cpr_d   = 1'b0;
        fft_d   = 1'b0;
        demap_d = 1'b0;
        p2s_d   = 1'b0;
        sym_d   = 1'b0;
        err_d   = 1'b0;
        bin_d   = bin_q;
        busy_d  = (state_nxt != IDLE);
        if (bus.abort) begin
            bin_d = '0;
        end else begin
            case (state)
                IDLE: if (bus.go) begin
                    cpr_d = 1'b1;
                    bin_d = '0;
                end
                CPR: if (match) fft_d = 1'b1;
                     else if (expire) begin err_d = 1'b1; bin_d = '0; end
                FFT: if (match) demap_d = 1'b1;
                     else if (expire) begin err_d = 1'b1; bin_d = '0; end
                DEMAP: if (match) p2s_d = 1'b1;
                       else if (expire) begin err_d = 1'b1; bin_d = '0; end
                P2S: if (match) begin
                         if (bin_q == LAST_BIN) begin
                             sym_d = 1'b1;
                             bin_d = '0;
                         end else begin
                             demap_d = 1'b1;
                             bin_d   = bin_q + 1'b1;
                         end
                     end else if (expire) begin
                         err_d = 1'b1;
                         bin_d = '0;
                     end
                default: bin_d = '0;
            endcase
        end
    end

    assign bus.CPR_start   = cpr_q;
    assign bus.FFT_start   = fft_q;
    assign bus.DEMAP_start = demap_q;
    assign bus.P2S_start   = p2s_q;
    assign bus.sym_done    = sym_q;
    assign bus.err         = err_q;
    assign bus.busy        = busy_q;
    assign bus.bin_idx     = bin_q;
    assign bus.state       = state;

endmodule
